bti_tcm: RTL and testbench
==========================

Name: bti_tcm

Overview:
- BTI responder (slave) that terminates one BTI request/response interface pair with a single-port word-addressed tightly coupled memory.
- Instantiated once for the ITCM and once for the DTCM, facing the core's BTI master ports.
- Read data returns with 1-cycle minimum latency.
- Responses are strictly in order and buffered in a small response FIFO so the master can backpressure without losing data.

Parameters:
- WORDS, 4096: memory depth in 32-bit words; power of two.
- BASE, 32'h0000_0000: byte base address of the memory window.
- RSP_DEPTH, 2: response FIFO entries; minimum 2; 2 sustains 1 req/cycle while rsp.rdy is high.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- bti_req_slv.vld  in  1  request valid.
- bti_req_slv.rdy  out  1  request ready.
- bti_req_slv.addr  in  32  byte address.
- bti_req_slv.cmd  in  1  0 = read, 1 = write.
- bti_req_slv.wdata  in  32  write data.
- bti_req_slv.wstrb  in  4  byte write enables.
- bti_rsp_mst.vld  out  1  response valid.
- bti_rsp_mst.rdy  in  1  response ready.
- bti_rsp_mst.rdata  out  32  read data (0 for writes).
- bti_rsp_mst.err  out  1  error response.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: req.rdy=0 during rst, s1_vld=0, FIFO count=0, rsp.vld=0, rsp.rdata=0, rsp.err=0. Memory array is not reset.
- Handshakes: a request is accepted when req.vld&&req.rdy. A response is consumed when rsp.vld&&rsp.rdy.
- Once asserted, rsp.vld and its payload stay stable until consumed.
- req.rdy = !rst && (fifo_cnt + s1_vld) < RSP_DEPTH. It is registered-state only, with no combinational path from rsp.rdy.
- Word index = addr[$clog2(WORDS)+1:2]. addr[1:0] is ignored; there is no misalignment error.
- Stage 0 (accept cycle N):
  - Write: bytes with wstrb[i]=1 are written at the clock edge. wstrb=0 writes nothing but still returns a response.
  - Read: the array is read synchronously.
  - s1_vld<=1 and the cmd/err tag is captured.
- Stage 1 (cycle N+1):
  - If the FIFO is empty, rsp is driven directly from s1 (bypass): rdata = array output for reads, 0 for writes.
  - If the bypass is not consumed that cycle, the s1 entry is pushed into the FIFO.
  - If the FIFO is non-empty, rsp is driven from the FIFO head and s1 is pushed at the tail.
- Latency: read/write response at N+1 when the FIFO is empty and rsp.rdy=1. Back-to-back accepts produce back-to-back responses.
- Ordering: responses are strictly in accept order.
- Read-after-write: a read accepted in cycle N+1 after a write accepted at N returns the new data.
- Full: at fifo_cnt + s1_vld == RSP_DEPTH, req.rdy=0. No overflow is possible.
- Simultaneous push and pop on the FIFO leaves the count unchanged. FIFO pointers wrap modulo RSP_DEPTH.
- Reset mid-operation: s1 and all FIFO entries are dropped with no response. A write already accepted before rst remains in memory.
- rst asserted in the same cycle as req.vld: no accept and no write.

Optional Feature:
- Macro: BTI_TCM_RANGE_CHK_EN.
- Defined: a request with addr outside [BASE, BASE+4*WORDS) is accepted normally, suppresses any array write, and returns err=1 with rdata=0.
- Undefined: the address is not checked. The upper address bits are ignored (aliasing), err is tied 0, and no compare logic is built.

Decomposition:
- bti_pkg holds:
  - the bti_cmd_e enum (BTI_RD=0, BTI_WR=1);
  - BTI_AW=32, BTI_DW=32, BTI_SW=4;
  - the rsp_entry_t struct {rdata, err}.
- One sub-module: bti_rsp_fifo. It is a synchronous FIFO of rsp_entry_t with depth RSP_DEPTH and count output, and the same clk/rst. The bypass mux stays in bti_tcm.

Test Plan:
- Write then read: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10 with rsp.rdy=1 → write rsp at N+1 with err=0; read rsp at N+1 with rdata=0xDEADBEEF.
- Byte strobe: preload 0x11223344 at 0x20, write 0xAABBCCDD with wstrb=0x5, read → 0x11BB33DD.
- Throughput: 8 back-to-back reads of 0x0..0x1C with rsp.rdy=1 → req.rdy stays 1 and 8 consecutive rsp.vld cycles in order.
- Backpressure: rsp.rdy=0 with 4 reads issued → exactly 2 accepted and req.rdy=0. Then rsp.rdy=1 → 2 responses in order, then the remaining reads proceed.
- Reset mid-operation: with 2 responses pending, assert rst for 1 cycle → rsp.vld=0 and count=0 afterwards. Pending responses are never delivered and memory keeps the written data.
- BTI_TCM_RANGE_CHK_EN defined: write to BASE+4*WORDS → err=1, rdata=0, and memory is unchanged (read of 0x0 returns its old value).

Source files
------------

// File: rtl/bti_pkg.sv
// Shared BTI bus definitions: command encoding, bus widths and the buffered response entry.
package bti_pkg;

    localparam int BTI_AW = 32;
    localparam int BTI_DW = 32;
    localparam int BTI_SW = 4;

    typedef enum logic {
        BTI_RD = 1'b0,
        BTI_WR = 1'b1
    } bti_cmd_e;

    typedef struct packed {
        logic [BTI_DW-1:0] rdata;
        logic              err;
    } rsp_entry_t;

endpackage

// File: rtl/bti_rsp_fifo.sv
// In-order response buffer of rsp_entry_t; push lands at the tail, head is visible the cycle after.
// Caller guarantees no push when full and no pop when empty; simultaneous push/pop keeps the count.
module bti_rsp_fifo
    import bti_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  rsp_entry_t      push_dat_i,
    input  logic            pop_i,
    output rsp_entry_t      head_dat_o,
    output logic [CW-1:0]   cnt_o,
    output logic            empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;
    assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/bti_tcm.sv
// BTI responder backed by a single-port word TCM: response at N+1, in order, held until rsp rdy.
// req rdy drops once buffered + in-flight responses reach RSP_DEPTH; BTI_TCM_RANGE_CHK_EN adds window check.
module bti_tcm
    import bti_pkg::*;
#(
    parameter int          WORDS     = 4096,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bti_req_vld_i,
    output logic               bti_req_rdy_o,
    input  logic [BTI_AW-1:0]  bti_req_addr_i,
    input  logic               bti_req_cmd_i,
    input  logic [BTI_DW-1:0]  bti_req_wdata_i,
    input  logic [BTI_SW-1:0]  bti_req_wstrb_i,
    output logic               bti_rsp_vld_o,
    input  logic               bti_rsp_rdy_i,
    output logic [BTI_DW-1:0]  bti_rsp_rdata_o,
    output logic               bti_rsp_err_o
);

    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [BTI_DW-1:0] mem [WORDS];

    logic              accept;
    logic              is_wr;
    logic              range_err;
    logic [IW-1:0]     word_idx;
    logic [CW:0]       occupancy;
    logic              unused_addr_bits;

    logic              s1_vld_q;
    logic              s1_wr_q;
    logic              s1_err_q;
    logic [BTI_DW-1:0] rd_q;

    rsp_entry_t        s1_ent;
    rsp_entry_t        head_ent;
    rsp_entry_t        rsp_ent;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              rsp_vld;

    assign word_idx         = bti_req_addr_i[IW+1:2];
    assign unused_addr_bits = ^{bti_req_addr_i[BTI_AW-1:IW+2], bti_req_addr_i[1:0]};
    assign is_wr            = (bti_cmd_e'(bti_req_cmd_i) == BTI_WR);

`ifdef BTI_TCM_RANGE_CHK_EN
    localparam logic [BTI_AW:0] WIN_BYTES = (BTI_AW + 1)'(WORDS) << 2;
    logic [BTI_AW:0] offset;
    // A borrow sets the top bit, so addresses below BASE also land out of range.
    assign offset    = {1'b0, bti_req_addr_i} - {1'b0, BASE};
    assign range_err = (offset >= WIN_BYTES);
`else
    assign range_err = 1'b0;
`endif

    // Ready depends only on registered occupancy, never on rsp rdy.
    assign occupancy     = {1'b0, fifo_cnt} + (CW + 1)'(s1_vld_q);
    assign bti_req_rdy_o = !rst && (occupancy < (CW + 1)'(RSP_DEPTH));
    assign accept        = bti_req_vld_i && bti_req_rdy_o;

    always_ff @(posedge clk) begin
        if (accept && is_wr && !range_err) begin
            for (int i = 0; i < BTI_SW; i++) begin
                if (bti_req_wstrb_i[i]) begin
                    mem[word_idx][8*i +: 8] <= bti_req_wdata_i[8*i +: 8];
                end
            end
        end
        if (accept && !is_wr) begin
            rd_q <= mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_wr_q  <= 1'b0;
            s1_err_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_wr_q  <= is_wr;
                s1_err_q <= range_err;
            end
        end
    end

    always_comb begin
        s1_ent.rdata = (s1_wr_q || s1_err_q) ? '0 : rd_q;
        s1_ent.err   = s1_err_q;
    end

    // Bypass the FIFO only when it is empty; otherwise s1 queues behind older responses.
    assign rsp_vld   = !fifo_empty || s1_vld_q;
    assign rsp_ent   = fifo_empty ? s1_ent : head_ent;
    assign fifo_pop  = !fifo_empty && bti_rsp_rdy_i;
    assign fifo_push = s1_vld_q && !(fifo_empty && bti_rsp_rdy_i);

    bti_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (s1_ent),
        .pop_i      (fifo_pop),
        .head_dat_o (head_ent),
        .cnt_o      (fifo_cnt),
        .empty_o    (fifo_empty)
    );

    assign bti_rsp_vld_o   = rsp_vld;
    assign bti_rsp_rdata_o = rsp_vld ? rsp_ent.rdata : '0;
    assign bti_rsp_err_o   = rsp_vld ? rsp_ent.err : 1'b0;

endmodule

// File: tb/tb_bti_tcm.sv
// Scoreboard bench for bti_tcm: driver pushes expected responses at accept, monitor pops on rsp handshake.
module tb_bti_tcm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_cmd;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   nvec   = 0;
    int   nmis   = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   stalls = 0;
    bit   lat_chk = 1'b0;

    bti_tcm #(
        .WORDS     (4096),
        .BASE      (32'h0000_0000),
        .RSP_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bti_req_vld_i   (req_vld),
        .bti_req_rdy_o   (req_rdy),
        .bti_req_addr_i  (req_addr),
        .bti_req_cmd_i   (req_cmd),
        .bti_req_wdata_i (req_wdata),
        .bti_req_wstrb_i (req_wstrb),
        .bti_rsp_vld_o   (rsp_vld),
        .bti_rsp_rdy_i   (rsp_rdy),
        .bti_rsp_rdata_o (rsp_rdata),
        .bti_rsp_err_o   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_vld && rsp_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                if (lat_chk) chk("rsp_latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    // Called and returns just after a rising edge, so back-to-back calls give back-to-back accepts.
    task automatic issue(input logic [31:0] addr, input logic cmd, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
        logic r;
        bit   done = 1'b0;
        req_vld   = 1'b1;
        req_addr  = addr;
        req_cmd   = cmd;
        req_wdata = wdata;
        req_wstrb = wstrb;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            r = req_rdy;
            if (!r) stalls++;
            @(posedge clk);
            if (r) begin
                q.push_back('{rdata: exp_rdata, err: exp_err, cyc: cyc});
                n_acc++;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'd1, 32'd0);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                      input logic exp_err);
        issue(addr, 1'b1, d, s, 32'h0, exp_err);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rdata);
        issue(addr, 1'b0, 32'h0, 4'h0, exp_rdata, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_vld   = 1'b0;
        req_addr  = '0;
        req_cmd   = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_rdy   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Write then read back with single-cycle latency.
        lat_chk = 1'b1;
        wr(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF);
        drain();

        // Byte strobes: only bytes 0 and 2 change.
        wr(32'h20, 32'h1122_3344, 4'hF, 1'b0);
        wr(32'h20, 32'hAABB_CCDD, 4'h5, 1'b0);
        rd(32'h20, 32'h11BB_33DD);
        wr(32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0);
        rd(32'h20, 32'h11BB_33DD);
        drain();

        // Throughput: eight back-to-back reads with no stall.
        for (int i = 0; i < 8; i++) wr(32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, 1'b0);
        drain();
        stalls = 0;
        for (int i = 0; i < 8; i++) rd(32'(4 * i), 32'hA5A5_0000 + 32'(i));
        chk("tp_stalls", stalls, 32'd0);
        drain();
        lat_chk = 1'b0;

        // Backpressure: only two reads fit while rsp rdy is low.
        rsp_rdy = 1'b0;
        n_acc   = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) rd(32'(4 * i), 32'hA5A5_0000 + 32'(i));
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepted", n_acc, 32'd2);
                chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
                chk("bp_rsp_vld", {31'd0, rsp_vld}, 32'd1);
                chk("bp_head", rsp_rdata, 32'hA5A5_0000);
                rsp_rdy = 1'b1;
            end
        join
        chk("bp_total", n_acc, 32'd4);
        drain();

        // Reset with two responses pending and a write presented during reset.
        wr(32'h44, 32'h0000_0055, 4'hF, 1'b0);
        drain();
        rsp_rdy = 1'b0;
        wr(32'h40, 32'hCAFE_F00D, 4'hF, 1'b0);
        rd(32'h08, 32'hA5A5_0002);
        rst       = 1'b1;
        req_vld   = 1'b1;
        req_addr  = 32'h44;
        req_cmd   = 1'b1;
        req_wdata = 32'h0000_0BAD;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        req_vld = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        @(negedge clk);
        chk("mid_rst_rsp_vld2", {31'd0, rsp_vld}, 32'd0);
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        rd(32'h40, 32'hCAFE_F00D);
        rd(32'h44, 32'h0000_0055);
        drain();

`ifdef BTI_TCM_RANGE_CHK_EN
        // Just past the window: error response, memory untouched.
        wr(32'h0000_4000, 32'h1357_2468, 4'hF, 1'b1);
        rd(32'h0, 32'hA5A5_0000);
`else
        // No range check: upper address bits alias onto word 0.
        wr(32'h0000_4000, 32'h1357_2468, 4'hF, 1'b0);
        rd(32'h0, 32'h1357_2468);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
